// File: rtl/seg7_scan_driver.sv
// Scanned driver for a 4-digit common-anode seven-segment display.
// Double-buffered digit capture with frame-boundary swap, guard interval and leading-zero blanking.
module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 16,
   parameter int unsigned BLANK_LEAD  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] dp_en,
   input  logic       load,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   typedef struct packed {
      logic [3:0][3:0] dig;
      logic [3:0]      dp_en;
   } frame_t;

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   frame_t           pend;
   frame_t           act;
   frame_t           in_frame;
   logic             pend_vld;
   logic             wrap;
   logic             boundary;
   logic             in_guard;
   logic [3:0]       blank;
   logic [3:0]       cur_dig;
   logic [3:0]       an_nxt;
   logic [6:0]       seg_nxt;
   logic             dp_nxt;

   // Active-low {g,f,e,d,c,b,a} pattern for a hex digit.
   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign in_frame = {{d3, d2, d1, d0}, dp_en};
   assign wrap     = (cnt == CNT_MAX);
   assign boundary = wrap && (idx == 2'd3);

   generate
      if (GUARD == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (cnt < CNT_W'(GUARD));
      end
   endgenerate

   // Slot prescaler and digit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (wrap) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Pending/active buffers; active only changes at a frame boundary so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= '0;
         act      <= '0;
         pend_vld <= 1'b0;
      end else if (load && boundary) begin
         act      <= in_frame;
         pend_vld <= 1'b0;
      end else if (load) begin
         pend     <= in_frame;
         pend_vld <= 1'b1;
      end else if (boundary && pend_vld) begin
         act      <= pend;
         pend_vld <= 1'b0;
      end
   end

   // Leading-zero chain from the leftmost digit; digit 0 always shows.
   always_comb begin
      blank    = 4'b0000;
      blank[3] = (BLANK_LEAD != 0) && (act.dig[3] == 4'h0);
      blank[2] = blank[3] && (act.dig[2] == 4'h0);
      blank[1] = blank[2] && (act.dig[1] == 4'h0);
   end

   always_comb begin
      an_nxt  = 4'b1111;
      seg_nxt = SEG_OFF;
      dp_nxt  = 1'b1;
      cur_dig = act.dig[idx];
      if (!in_guard) begin
         an_nxt  = ~(4'b0001 << idx);
         seg_nxt = blank[idx] ? SEG_OFF : seg_decode(cur_dig);
         dp_nxt  = ~act.dp_en[idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 4'b1111;
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expectations keyed by output cycle, checked by a negedge monitor.
module tb_seg7_scan_driver;
   localparam int unsigned RD = 8;
   localparam int unsigned GD = 2;
   localparam logic [6:0] OFF = 7'b1111111;
   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, SA = 7'b0001000, SD = 7'b0100001;
   localparam logic [6:0] SE = 7'b0000110, SF = 7'b0001110;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] d0, d1, d2, d3, dp_en;
   logic       load;
   logic [3:0] an_b, an_n;
   logic [6:0] seg_b, seg_n;
   logic       dp_b, dp_n;
   int         cyc;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      int         cyc;
      bit         noblank;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      string      name;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LEAD(1)) dut (
      .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .dp_en(dp_en), .load(load), .an(an_b), .seg(seg_b), .dp(dp_b));

   seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LEAD(0)) dut_noblank (
      .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .dp_en(dp_en), .load(load), .an(an_n), .seg(seg_n), .dp(dp_n));

   // Output cycle k = state of the k-th rising edge after reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [3:0] a, input logic [6:0] s, input logic d,
                        input logic [3:0] ea, input logic [6:0] es, input logic ed);
      checks++;
      if (a !== ea || s !== es || d !== ed) begin
         errors++;
         $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                  name, a, s, d, ea, es, ed);
      end
   endtask

   task automatic exp_b(input int c, input string n, input logic [3:0] a, input logic [6:0] s, input logic d);
      sb.push_back('{c, 1'b0, a, s, d, $sformatf("%s@%0d", n, c)});
   endtask

   task automatic exp_n(input int c, input string n, input logic [3:0] a, input logic [6:0] s, input logic d);
      sb.push_back('{c, 1'b1, a, s, d, $sformatf("noblank_%s@%0d", n, c)});
   endtask

   // Monitor: compare every expectation due this cycle, flag any that slipped past.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
               if (sb[i].noblank) check(sb[i].name, an_n, seg_n, dp_n, sb[i].an, sb[i].seg, sb[i].dp);
               else               check(sb[i].name, an_b, seg_b, dp_b, sb[i].an, sb[i].seg, sb[i].dp);
               sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
               checks++;
               errors++;
               $display("FAIL %s: expectation never sampled, now at cycle %0d", sb[i].name, cyc);
               sb.delete(i);
            end
         end
      end
   end

   task automatic wait_cyc(input int k);
      int guard = 0;
      while (cyc != k && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != k) begin
         checks++;
         errors++;
         $display("FAIL wait_cyc: cycle %0d not reached, at %0d", k, cyc);
      end
   endtask

   // Drive load so that it is sampled by rising edge k.
   task automatic do_load(input int k, input logic [3:0] v3, input logic [3:0] v2,
                          input logic [3:0] v1, input logic [3:0] v0, input logic [3:0] dpe);
      wait_cyc(k - 1);
      d3 = v3; d2 = v2; d1 = v1; d0 = v0; dp_en = dpe;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0; dp_en = 4'h0; load = 1'b0;

      // Frame 0: reset content, guard/scan timing
      exp_b(1, "guard", 4'b1111, OFF, 1'b1);
      exp_b(2, "guard", 4'b1111, OFF, 1'b1);
      exp_b(3, "slot0_first", 4'b1110, S0, 1'b1);
      exp_b(8, "slot0_last", 4'b1110, S0, 1'b1);
      exp_b(9, "guard_slot1", 4'b1111, OFF, 1'b1);
      exp_b(10, "guard_slot1", 4'b1111, OFF, 1'b1);
      exp_b(11, "slot1_blank", 4'b1101, OFF, 1'b1);
      exp_b(19, "slot2_blank", 4'b1011, OFF, 1'b1);
      exp_n(3, "slot0_zero", 4'b1110, S0, 1'b1);
      exp_n(11, "slot1_zero", 4'b1101, S0, 1'b1);
      exp_n(19, "slot2_zero", 4'b1011, S0, 1'b1);
      exp_b(27, "pending_hidden", 4'b0111, OFF, 1'b1);
      exp_b(32, "boundary_old", 4'b0111, OFF, 1'b1);
      exp_b(33, "guard_frame1", 4'b1111, OFF, 1'b1);
      // Frame 1: digits 1,2,3,4 with dp on digit 2
      exp_b(35, "digit4", 4'b1110, S4, 1'b1);
      exp_b(43, "digit3", 4'b1101, S3, 1'b1);
      exp_b(51, "digit2_dp", 4'b1011, S2, 1'b0);
      exp_b(59, "digit1", 4'b0111, S1, 1'b1);
      exp_n(59, "digit1", 4'b0111, S1, 1'b1);
      exp_b(91, "old_until_boundary", 4'b0111, S1, 1'b1);
      // Frame 3: digits 0,0,5,0
      exp_b(99, "lz_slot0", 4'b1110, S0, 1'b1);
      exp_b(107, "lz_slot1", 4'b1101, S5, 1'b1);
      exp_b(115, "lz_slot2", 4'b1011, OFF, 1'b1);
      exp_b(123, "lz_slot3", 4'b0111, OFF, 1'b1);
      exp_n(115, "lz_slot2", 4'b1011, S0, 1'b1);
      exp_n(123, "lz_slot3", 4'b0111, S0, 1'b1);
      // Frame 4: hex F,E,d,A
      exp_b(131, "hex_A", 4'b1110, SA, 1'b1);
      exp_b(139, "hex_d", 4'b1101, SD, 1'b1);
      exp_b(147, "hex_E", 4'b1011, SE, 1'b1);
      exp_b(155, "hex_F", 4'b0111, SF, 1'b1);
      // Frame 5 keeps hex while two loads are pending; frame 6 shows only the latest
      exp_b(187, "hex_kept", 4'b0111, SF, 1'b1);
      exp_b(195, "latest_load_s0", 4'b1110, S2, 1'b1);
      exp_b(203, "latest_load_s1", 4'b1101, S2, 1'b1);
      exp_b(211, "latest_load_s2", 4'b1011, S2, 1'b1);
      exp_b(219, "latest_load_s3", 4'b0111, S2, 1'b1);
      // Load in the boundary cycle goes straight to active
      exp_b(224, "boundary_load_old", 4'b0111, S2, 1'b1);
      exp_b(225, "boundary_load_guard", 4'b1111, OFF, 1'b1);
      exp_b(227, "boundary_load_s0", 4'b1110, S3, 1'b0);
      exp_b(235, "boundary_load_s1", 4'b1101, S3, 1'b0);
      exp_b(276, "pre_reset_slot2", 4'b1011, S3, 1'b0);

      repeat (3) @(negedge clk);
      check("reset_hold", an_b, seg_b, dp_b, 4'b1111, OFF, 1'b1);
      check("reset_hold_noblank", an_n, seg_n, dp_n, 4'b1111, OFF, 1'b1);
      rst_n = 1'b1;

      do_load(20, 4'h1, 4'h2, 4'h3, 4'h4, 4'b0100);
      do_load(70, 4'h0, 4'h0, 4'h5, 4'h0, 4'b0000);
      do_load(100, 4'hF, 4'hE, 4'hD, 4'hA, 4'b0000);
      do_load(165, 4'h1, 4'h1, 4'h1, 4'h1, 4'b0000);
      do_load(175, 4'h2, 4'h2, 4'h2, 4'h2, 4'b0000);
      do_load(224, 4'h3, 4'h3, 4'h3, 4'h3, 4'b1111);
      do_load(260, 4'h7, 4'h7, 4'h7, 4'h7, 4'b0000);

      // Mid-slot-2 reset: outputs drop without a clock edge
      wait_cyc(276);
      #2 rst_n = 1'b0;
      #1;
      check("reset_async", an_b, seg_b, dp_b, 4'b1111, OFF, 1'b1);
      check("reset_async_noblank", an_n, seg_n, dp_n, 4'b1111, OFF, 1'b1);

      exp_b(1, "rst2_guard", 4'b1111, OFF, 1'b1);
      exp_b(3, "rst2_slot0", 4'b1110, S0, 1'b1);
      exp_b(11, "rst2_slot1_blank", 4'b1101, OFF, 1'b1);
      exp_n(11, "rst2_slot1_zero", 4'b1101, S0, 1'b1);
      exp_b(35, "rst2_pending_dropped", 4'b1110, S0, 1'b1);
      exp_b(51, "rst2_dp_cleared", 4'b1011, OFF, 1'b1);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(53);

      while (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: expectation left unchecked", sb[0].name);
         void'(sb.pop_front());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
